// File: rtl/pearson_hash_core_if.sv
// Host/stream bundle for pearson_hash_core: table side port, message stream,
// hash result stream and an FSM state debug tap.
interface pearson_hash_core_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  init_done;
    logic                  tbl_we;
    logic [DATA_WIDTH-1:0] tbl_addr;
    logic [DATA_WIDTH-1:0] tbl_wdata;
    logic                  tbl_rd_en;
    logic [DATA_WIDTH-1:0] tbl_rdata;
    logic                  tbl_rvalid;
    logic                  tbl_err;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;
    logic                  in_ready;
    logic                  hash_valid;
    logic [DATA_WIDTH-1:0] hash_out;
    logic                  hash_ready;
    logic [1:0]            dbg_state;

    // Handshakes: a word/hash moves on a clock edge where valid and ready are
    // both high; valid and its payload must stay stable until that edge.
    modport master (
        input  init_done, tbl_rdata, tbl_rvalid, tbl_err, in_ready,
               hash_valid, hash_out, dbg_state,
        output tbl_we, tbl_addr, tbl_wdata, tbl_rd_en, in_valid, in_data,
               in_last, hash_ready
    );

    modport slave (
        output init_done, tbl_rdata, tbl_rvalid, tbl_err, in_ready,
               hash_valid, hash_out, dbg_state,
        input  tbl_we, tbl_addr, tbl_wdata, tbl_rd_en, in_valid, in_data,
               in_last, hash_ready
    );
endinterface

// File: rtl/pearson_hash_core.sv
// Pearson hash engine with a self-initialising 2^DATA_WIDTH permutation table.
// Define PEARSON_INIT_SCRAMBLE_EN to init T[p] = 5*p + 1 instead of T[p] = p.
module pearson_hash_core #(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] HASH_SEED  = '0
) (
    input  logic                clk,
    input  logic                rst,
    pearson_hash_core_if.slave  bus
);
    localparam int DEPTH = 1 << DATA_WIDTH;

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_HASH = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [DATA_WIDTH-1:0] PTR_LAST = '1;
    localparam logic [DATA_WIDTH-1:0] ONE      = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] r_table [0:DEPTH-1];
    logic [1:0]            r_state;
    logic [DATA_WIDTH-1:0] r_ptr;
    logic [DATA_WIDTH-1:0] r_h;
    logic                  r_init_done;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rvalid;
    logic                  r_err;
    logic                  r_hash_valid;
    logic [DATA_WIDTH-1:0] r_hash_out;

    logic                  w_in_ready;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_next_h;
    logic [DATA_WIDTH-1:0] w_init_val;

`ifdef PEARSON_INIT_SCRAMBLE_EN
    // Odd multiplier keeps the map a bijection modulo 2^DATA_WIDTH.
    assign w_init_val = (r_ptr << 2) + r_ptr + ONE;
`else
    assign w_init_val = r_ptr;
`endif

    // A host table write in IDLE wins over a word offered in the same cycle.
    assign w_in_ready = ((r_state == ST_IDLE) && !bus.tbl_we) || (r_state == ST_HASH);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_next_h   = r_table[r_h ^ bus.in_data];

    // Table array carries no reset; INIT rewrites every entry after reset.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_table[r_ptr] <= w_init_val;
        end else if ((r_state == ST_IDLE) && bus.tbl_we) begin
            r_table[bus.tbl_addr] <= bus.tbl_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_INIT;
            r_ptr        <= '0;
            r_h          <= HASH_SEED;
            r_init_done  <= 1'b0;
            r_rdata      <= '0;
            r_rvalid     <= 1'b0;
            r_err        <= 1'b0;
            r_hash_valid <= 1'b0;
            r_hash_out   <= '0;
        end else begin
            r_rvalid <= bus.tbl_rd_en && (r_state != ST_INIT);
            if (bus.tbl_rd_en && (r_state != ST_INIT)) begin
                r_rdata <= r_table[bus.tbl_addr];
            end
            r_err <= bus.tbl_we && ((r_state == ST_HASH) || (r_state == ST_DONE));

            case (r_state)
                ST_INIT: begin
                    r_ptr <= r_ptr + ONE;
                    if (r_ptr == PTR_LAST) begin
                        r_state     <= ST_IDLE;
                        r_init_done <= 1'b1;
                    end
                end
                ST_IDLE, ST_HASH: begin
                    if (w_accept) begin
                        r_h <= w_next_h;
                        if (bus.in_last) begin
                            r_state      <= ST_DONE;
                            r_hash_out   <= w_next_h;
                            r_hash_valid <= 1'b1;
                        end else begin
                            r_state <= ST_HASH;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.hash_ready) begin
                        r_hash_valid <= 1'b0;
                        r_h          <= HASH_SEED;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign bus.init_done  = r_init_done;
    assign bus.tbl_rdata  = r_rdata;
    assign bus.tbl_rvalid = r_rvalid;
    assign bus.tbl_err    = r_err;
    assign bus.in_ready   = w_in_ready;
    assign bus.hash_valid = r_hash_valid;
    assign bus.hash_out   = r_hash_out;
    assign bus.dbg_state  = r_state;
endmodule
